hit_width_monit: RTL and testbench

HIT_WIDTH_MONIT -- requirements
Module: hit_width_monit

---
 rtl/hit_width_monit.sv | 206 ++++++++++++++++++++
 tb/tb_hit_width_monit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/hit_width_monit.sv
// Per-channel hit counter and pulse-width monitor with stuck-high detection.
// One hwm_chan instance per channel; the top adds the snapshot port and error summary.

module hwm_chan #(
    parameter int CNT_W  = 16,
    parameter int WCNT_W = 5,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              live,
    input  logic              hit,
    input  logic              clr,
    input  logic [WCNT_W-1:0] win_min,
    input  logic [WCNT_W-1:0] win_max,
    output logic [CNT_W-1:0]  cnt,
    output logic [ERR_W-1:0]  err,
    output logic [WCNT_W-1:0] last_w,
    output logic              stuck,
    output logic              err_nz
);

    typedef enum logic [1:0] {IDLE, CNT, STUCK} state_t;

    // Width one below saturation: the increment that reaches all-ones means stuck.
    localparam logic [WCNT_W-1:0] W_PRE = {{(WCNT_W-1){1'b1}}, 1'b0};

    state_t            state, state_nxt;
    logic              hit_q;
    logic              rise;
    logic [WCNT_W-1:0] width;
    logic              err_pend;
    logic              err_evt, w_load, w_inc, w_latch, stuck_set;

    // live stays low for the first clock after reset so a line already high is not an edge
    assign rise   = live & hit & ~hit_q;
    assign err_nz = |err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      state <= IDLE;
        else if (clr) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        err_evt   = 1'b0;
        w_load    = 1'b0;
        w_inc     = 1'b0;
        w_latch   = 1'b0;
        stuck_set = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = CNT;
                    w_load    = 1'b1;
                end
            end
            CNT: begin
                if (hit) begin
                    w_inc = 1'b1;
                    if (width == W_PRE) begin
                        state_nxt = STUCK;
                        stuck_set = 1'b1;
                        err_evt   = 1'b1;
                    end
                end else begin
                    // An inverted window (min > max) makes every width fail one of the two tests.
                    w_latch   = 1'b1;
                    err_evt   = (width < win_min) || (width > win_max);
                    state_nxt = IDLE;
                end
            end
            STUCK: begin
                if (!hit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q    <= 1'b0;
            cnt      <= '0;
            err      <= '0;
            last_w   <= '0;
            stuck    <= 1'b0;
            width    <= '0;
            err_pend <= 1'b0;
        end else begin
            hit_q <= hit;
            if (clr) begin
                cnt      <= '0;
                err      <= '0;
                last_w   <= '0;
                stuck    <= 1'b0;
                width    <= '0;
                err_pend <= 1'b0;
            end else begin
                if (rise)      cnt    <= cnt + CNT_W'(1);
                if (w_load)    width  <= WCNT_W'(1);
                else if (w_inc) width <= width + WCNT_W'(1);
                if (w_latch)   last_w <= width;
                if (stuck_set) stuck  <= 1'b1;
                err_pend <= err_evt;
                if (err_pend && (err != '1)) err <= err + ERR_W'(1);
            end
        end
    end

endmodule

module hit_width_monit #(
    parameter int N_CH   = 13,
    parameter int CNT_W  = 16,
    parameter int WCNT_W = 5,
    parameter int ERR_W  = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [N_CH-1:0]   hit_syn_in,
    input  logic [WCNT_W-1:0] win_min_in,
    input  logic [WCNT_W-1:0] win_max_in,
    input  logic              clr_in,
    input  logic              snap_in,
    input  logic [3:0]        ch_sel_in,
    output logic [CNT_W-1:0]  snap_cnt_out,
    output logic [ERR_W-1:0]  snap_err_out,
    output logic [WCNT_W-1:0] snap_width_out,
    output logic              snap_valid_out,
    output logic [N_CH-1:0]   stuck_out,
    output logic              err_any_out
);

    logic                           live;
    logic [N_CH-1:0][CNT_W-1:0]     cnt;
    logic [N_CH-1:0][ERR_W-1:0]     err;
    logic [N_CH-1:0][WCNT_W-1:0]    last_w;
    logic [N_CH-1:0]                err_nz;
    logic                           sel_ok;
    logic [CNT_W-1:0]               sel_cnt;
    logic [ERR_W-1:0]               sel_err;
    logic [WCNT_W-1:0]              sel_w;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) live <= 1'b0;
        else        live <= 1'b1;
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        hwm_chan #(
            .CNT_W  (CNT_W),
            .WCNT_W (WCNT_W),
            .ERR_W  (ERR_W)
        ) u_ch (
            .clk     (clk_in),
            .rst     (rst_in),
            .live    (live),
            .hit     (hit_syn_in[g]),
            .clr     (clr_in),
            .win_min (win_min_in),
            .win_max (win_max_in),
            .cnt     (cnt[g]),
            .err     (err[g]),
            .last_w  (last_w[g]),
            .stuck   (stuck_out[g]),
            .err_nz  (err_nz[g])
        );
    end

    assign sel_ok = (5'(ch_sel_in) < 5'(N_CH));

    always_comb begin
        sel_cnt = '0;
        sel_err = '0;
        sel_w   = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_sel_in == 4'(i)) begin
                sel_cnt = cnt[i];
                sel_err = err[i];
                sel_w   = last_w[i];
            end
        end
    end

    // Samples pre-edge values, so a snapshot alongside clr_in sees the data being cleared.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            snap_cnt_out   <= '0;
            snap_err_out   <= '0;
            snap_width_out <= '0;
            snap_valid_out <= 1'b0;
            err_any_out    <= 1'b0;
        end else begin
            snap_valid_out <= 1'b0;
            if (snap_in && sel_ok) begin
                snap_cnt_out   <= sel_cnt;
                snap_err_out   <= sel_err;
                snap_width_out <= sel_w;
                snap_valid_out <= 1'b1;
            end
            err_any_out <= |err_nz;
        end
    end

endmodule

// File: tb/tb_hit_width_monit.sv
// Directed bench for hit_width_monit: width window, stuck detection, wrap/saturation,
// snapshot/clear interaction and reset behaviour.

module tb_hit_width_monit;

    localparam int N_CH   = 13;
    localparam int CNT_W  = 4;
    localparam int WCNT_W = 5;
    localparam int ERR_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N_CH-1:0]   hit;
    logic [WCNT_W-1:0] win_min, win_max;
    logic              clr, snap;
    logic [3:0]        ch_sel;
    logic [CNT_W-1:0]  snap_cnt;
    logic [ERR_W-1:0]  snap_err;
    logic [WCNT_W-1:0] snap_width;
    logic              snap_valid;
    logic [N_CH-1:0]   stuck;
    logic              err_any;

    int n_checks = 0;
    int n_fail   = 0;

    always #10 clk = ~clk;

    hit_width_monit #(.N_CH(N_CH), .CNT_W(CNT_W), .WCNT_W(WCNT_W), .ERR_W(ERR_W)) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .hit_syn_in     (hit),
        .win_min_in     (win_min),
        .win_max_in     (win_max),
        .clr_in         (clr),
        .snap_in        (snap),
        .ch_sel_in      (ch_sel),
        .snap_cnt_out   (snap_cnt),
        .snap_err_out   (snap_err),
        .snap_width_out (snap_width),
        .snap_valid_out (snap_valid),
        .stuck_out      (stuck),
        .err_any_out    (err_any)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // hit high for w sampled edges, then low for the falling-edge edge
    task automatic pulse(input int ch, input int w);
        hit[ch] = 1'b1;
        tick(w);
        hit[ch] = 1'b0;
        tick(1);
    endtask

    // after return the snapshot edge has passed and outputs are sampled-ready
    task automatic do_snap(input int ch);
        snap   = 1'b1;
        ch_sel = 4'(ch);
        tick(1);
        snap   = 1'b0;
    endtask

    task automatic clear();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; hit = '0; clr = 1'b0; snap = 1'b0; ch_sel = '0;
        win_min = 5'd4; win_max = 5'd12;
        #25;
        n_checks++; if (snap_cnt !== 4'd0)   begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", snap_cnt); end
        n_checks++; if (snap_err !== 8'd0)   begin n_fail++; $display("FAIL reset_err: got %0d want 0", snap_err); end
        n_checks++; if (snap_width !== 5'd0) begin n_fail++; $display("FAIL reset_width: got %0d want 0", snap_width); end
        n_checks++; if (snap_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", snap_valid); end
        n_checks++; if (stuck !== 13'd0)     begin n_fail++; $display("FAIL reset_stuck: got %h want 0", stuck); end
        n_checks++; if (err_any !== 1'b0)    begin n_fail++; $display("FAIL reset_err_any: got %b want 0", err_any); end
        @(negedge clk);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_basic();
        pulse(3, 8);
        tick(3);
        do_snap(3);
        n_checks++; if (snap_cnt !== 4'd1)   begin n_fail++; $display("FAIL basic_cnt: got %0d want 1", snap_cnt); end
        n_checks++; if (snap_err !== 8'd0)   begin n_fail++; $display("FAIL basic_err: got %0d want 0", snap_err); end
        n_checks++; if (snap_width !== 5'd8) begin n_fail++; $display("FAIL basic_width: got %0d want 8", snap_width); end
        n_checks++; if (snap_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", snap_valid); end
        n_checks++; if (err_any !== 1'b0)    begin n_fail++; $display("FAIL basic_err_any: got %b want 0", err_any); end
        tick(1);
        n_checks++; if (snap_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop: got %b want 0", snap_valid); end
    endtask

    task automatic test_window();
        pulse(0, 3);
        tick(2);
        pulse(0, 13);
        tick(3);
        n_checks++; if (err_any !== 1'b1)     begin n_fail++; $display("FAIL win_err_any: got %b want 1", err_any); end
        do_snap(0);
        n_checks++; if (snap_err !== 8'd2)    begin n_fail++; $display("FAIL win_err: got %0d want 2", snap_err); end
        n_checks++; if (snap_width !== 5'd13) begin n_fail++; $display("FAIL win_width: got %0d want 13", snap_width); end
        pulse(4, 4);
        tick(1);
        pulse(4, 12);
        tick(3);
        do_snap(4);
        n_checks++; if (snap_err !== 8'd0)    begin n_fail++; $display("FAIL win_edge_err: got %0d want 0", snap_err); end
        n_checks++; if (snap_cnt !== 4'd2)    begin n_fail++; $display("FAIL win_edge_cnt: got %0d want 2", snap_cnt); end
        n_checks++; if (snap_width !== 5'd12) begin n_fail++; $display("FAIL win_edge_width: got %0d want 12", snap_width); end
        pulse(6, 1);
        tick(3);
        do_snap(6);
        n_checks++; if (snap_width !== 5'd1)  begin n_fail++; $display("FAIL one_clk_width: got %0d want 1", snap_width); end
        n_checks++; if (snap_err !== 8'd1)    begin n_fail++; $display("FAIL one_clk_err: got %0d want 1", snap_err); end
    endtask

    task automatic test_inverted();
        win_min = 5'd12; win_max = 5'd4;
        pulse(7, 8);
        tick(3);
        do_snap(7);
        n_checks++; if (snap_err !== 8'd1) begin n_fail++; $display("FAIL inv_err: got %0d want 1", snap_err); end
        win_min = 5'd4; win_max = 5'd12;
    endtask

    task automatic test_stuck();
        hit[5] = 1'b1;
        tick(30);
        n_checks++; if (stuck[5] !== 1'b0) begin n_fail++; $display("FAIL stuck_early: got %b want 0", stuck[5]); end
        tick(1);
        n_checks++; if (stuck[5] !== 1'b1) begin n_fail++; $display("FAIL stuck_at_31: got %b want 1", stuck[5]); end
        tick(9);
        hit[5] = 1'b0;
        tick(3);
        do_snap(5);
        n_checks++; if (snap_err !== 8'd1) begin n_fail++; $display("FAIL stuck_err: got %0d want 1", snap_err); end
        n_checks++; if (snap_cnt !== 4'd1) begin n_fail++; $display("FAIL stuck_cnt: got %0d want 1", snap_cnt); end
        tick(5);
        n_checks++; if (stuck[5] !== 1'b1) begin n_fail++; $display("FAIL stuck_hold: got %b want 1", stuck[5]); end
        clear();
        n_checks++; if (stuck !== 13'd0)   begin n_fail++; $display("FAIL stuck_clr: got %h want 0", stuck); end
        n_checks++; if (snap_err !== 8'd1) begin n_fail++; $display("FAIL snap_kept_on_clr: got %0d want 1", snap_err); end
        tick(2);
        n_checks++; if (err_any !== 1'b0)  begin n_fail++; $display("FAIL clr_err_any: got %b want 0", err_any); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 17; i++) pulse(1, 5);
        tick(3);
        do_snap(1);
        n_checks++; if (snap_cnt !== 4'd1) begin n_fail++; $display("FAIL wrap_cnt: got %0d want 1", snap_cnt); end
        n_checks++; if (snap_err !== 8'd0) begin n_fail++; $display("FAIL wrap_err: got %0d want 0", snap_err); end
        for (int i = 0; i < 300; i++) pulse(8, 1);
        tick(3);
        do_snap(8);
        n_checks++; if (snap_err !== 8'd255) begin n_fail++; $display("FAIL sat_err: got %0d want 255", snap_err); end
        n_checks++; if (snap_cnt !== 4'd12)  begin n_fail++; $display("FAIL sat_cnt: got %0d want 12", snap_cnt); end
    endtask

    task automatic test_snap_clr();
        clear();
        for (int i = 0; i < 5; i++) pulse(2, 5);
        tick(3);
        snap = 1'b1; clr = 1'b1; ch_sel = 4'd2;
        tick(1);
        snap = 1'b0; clr = 1'b0;
        n_checks++; if (snap_cnt !== 4'd5)   begin n_fail++; $display("FAIL snapclr_cnt: got %0d want 5", snap_cnt); end
        n_checks++; if (snap_valid !== 1'b1) begin n_fail++; $display("FAIL snapclr_valid: got %b want 1", snap_valid); end
        do_snap(13);
        n_checks++; if (snap_valid !== 1'b0) begin n_fail++; $display("FAIL oob_valid: got %b want 0", snap_valid); end
        n_checks++; if (snap_cnt !== 4'd5)   begin n_fail++; $display("FAIL oob_hold: got %0d want 5", snap_cnt); end
        do_snap(2);
        n_checks++; if (snap_cnt !== 4'd0)   begin n_fail++; $display("FAIL postclr_cnt: got %0d want 0", snap_cnt); end
    endtask

    task automatic test_clr_vs_edge();
        hit[9] = 1'b1; clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tick(4);
        hit[9] = 1'b0;
        tick(3);
        do_snap(9);
        n_checks++; if (snap_cnt !== 4'd0)   begin n_fail++; $display("FAIL clr_edge_cnt: got %0d want 0", snap_cnt); end
        n_checks++; if (snap_width !== 5'd0) begin n_fail++; $display("FAIL clr_edge_width: got %0d want 0", snap_width); end
    endtask

    task automatic test_reset_mid();
        pulse(10, 1);
        tick(4);
        n_checks++; if (err_any !== 1'b1) begin n_fail++; $display("FAIL pre_rst_err_any: got %b want 1", err_any); end
        hit[10] = 1'b1;
        tick(2);
        #4 rst = 1'b1;
        #1;
        n_checks++; if (err_any !== 1'b0)  begin n_fail++; $display("FAIL rst_async_err_any: got %b want 0", err_any); end
        n_checks++; if (snap_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_async_cnt: got %0d want 0", snap_cnt); end
        @(negedge clk);
        rst = 1'b0;
        tick(3);
        hit[10] = 1'b0;
        tick(2);
        do_snap(10);
        n_checks++; if (snap_cnt !== 4'd0)   begin n_fail++; $display("FAIL rst_high_cnt: got %0d want 0", snap_cnt); end
        n_checks++; if (snap_err !== 8'd0)   begin n_fail++; $display("FAIL rst_high_err: got %0d want 0", snap_err); end
        n_checks++; if (snap_width !== 5'd0) begin n_fail++; $display("FAIL rst_high_width: got %0d want 0", snap_width); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_window();
        test_inverted();
        test_stuck();
        test_wrap();
        test_snap_clr();
        test_clr_vs_edge();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
